core_run_ctrl: RTL

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_run_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : core_run_ctrl                                                |
// | Description : Run controller for a small core: gates host instruction-     |
// |               memory loads, sequences IDLE/CLR/RUN/DONE, counts RUN cycles.|
// |               Optional watchdog enabled by macro CORE_RUN_CYCLE_LIMIT_EN.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module core_run_ctrl #(
  parameter int IMEM_AW    = 8,
  parameter int MAX_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [6:0]         i_opcode,
  input  logic               i_host_we,
  input  logic [IMEM_AW-1:0] i_host_addr,
  input  logic [31:0]        i_host_wdata,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_wdata,
  output logic               o_core_reset_n,
  output logic               o_run_pc,
  output logic               o_running,
  output logic               o_done,
  output logic [31:0]        o_cycle_cnt,
  output logic               o_wr_reject,
  output logic               o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [6:0] c_op_system = 7'b1110011;

  state_t      r_state;
  state_t      w_next;
  logic        w_host_open;
  logic        w_halt;
  logic        w_limit;
  logic        r_core_reset_n;
  logic        r_run_pc;
  logic        r_running;
  logic        r_done;
  logic        r_wr_reject;
  logic [31:0] r_cycle_cnt;

  assign w_host_open = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_halt      = (r_state == S_RUN) && (i_opcode == c_op_system);

`ifdef CORE_RUN_CYCLE_LIMIT_EN
  // The RUN cycle that lifts the count onto MAX_CYCLES is the last one.
  localparam logic [31:0] c_limit_m1 = 32'(MAX_CYCLES - 1);
  logic r_timeout;

  assign w_limit   = (r_state == S_RUN) && (r_cycle_cnt >= c_limit_m1);
  assign o_timeout = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= 1'b0;
    end else if (w_next == S_CLR) begin
      r_timeout <= 1'b0;
    end else if (w_limit) begin
      r_timeout <= 1'b1;
    end
  end
`else
  logic w_unused_max;
  assign w_unused_max = ^32'(MAX_CYCLES);
  assign w_limit      = 1'b0;
  assign o_timeout    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_run) w_next = S_CLR;
      S_DONE:  if (i_run) w_next = S_CLR;
      S_CLR:   w_next = S_RUN;
      S_RUN:   if (w_halt || w_limit) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_core_reset_n <= 1'b0;
      r_run_pc       <= 1'b0;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_wr_reject    <= 1'b0;
      r_cycle_cnt    <= 32'd0;
    end else begin
      r_state        <= w_next;
      r_core_reset_n <= (w_next != S_CLR);
      r_run_pc       <= (w_next == S_RUN);
      r_running      <= (w_next == S_RUN);
      r_done         <= (w_next == S_DONE);
      r_wr_reject    <= i_host_we && !w_host_open;
      if (w_next == S_CLR) begin
        r_cycle_cnt <= 32'd0;
      end else if ((r_state == S_RUN) && (r_cycle_cnt != 32'hFFFF_FFFF)) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
    end
  end

  assign o_imem_we      = i_host_we && w_host_open;
  assign o_imem_addr    = o_imem_we ? i_host_addr  : '0;
  assign o_imem_wdata   = o_imem_we ? i_host_wdata : 32'd0;
  assign o_core_reset_n = r_core_reset_n;
  assign o_run_pc       = r_run_pc;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_cycle_cnt    = r_cycle_cnt;
  assign o_wr_reject    = r_wr_reject;

endmodule
`default_nettype wire
